lgn_class_scheduler: RTL and testbench

Sequencer for the logic-gate-network MNIST datapath. It loads one 256-bit input image into the net's input shift register one byte per handshake, then waits a fixed settle time for the combinational net. It then sweeps a class select across the shared popcount so that one summed group is scored per cycle. It tracks the arg-max and presents the winning class and its score through a valid/ready result port.

---
 rtl/lgn_class_scheduler.sv | 167 ++++++++++++++++
 tb/tb_lgn_class_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lgn_class_scheduler.sv
// Sequencer for the logic-gate-network MNIST datapath: byte-wise image load, settle wait,
// class sweep over the shared popcount with arg-max. Define LGN_SCHED_MARGIN_EN for result_margin.
//
// state  | meaning
// LOAD   | accept input bytes, pulse x_shift per byte
// SETTLE | wait for the combinational net to settle
// SCORE  | sweep class_sel, sample score one cycle behind, track arg-max
// DONE   | hold result until the consumer takes it
module lgn_class_scheduler #(
    parameter int INPUT_BYTES   = 32,
    parameter int CLASSES       = 10,
    parameter int SCORE_W       = 9,
    parameter int SETTLE_CYCLES = 4,
    localparam int CLASS_W      = $clog2(CLASSES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                x_shift,
    output logic [7:0]          x_byte,
    output logic [CLASS_W-1:0]  class_sel,
    input  logic [SCORE_W-1:0]  score,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [CLASS_W-1:0]  result_class,
    output logic [SCORE_W-1:0]  result_score,
`ifdef LGN_SCHED_MARGIN_EN
    output logic [SCORE_W-1:0]  result_margin,
`endif
    output logic                busy
);

    localparam int CNT_W = (INPUT_BYTES > 1) ? $clog2(INPUT_BYTES) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int PH_W  = $clog2(CLASSES + 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_SCORE,
        ST_DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     byte_cnt;
    logic [SET_W-1:0]     settle_cnt;
    logic [PH_W-1:0]      phase;
    logic [SCORE_W-1:0]   best_score;
    logic [CLASS_W-1:0]   best_class;
    logic [SCORE_W-1:0]   nxt_best_score;
    logic [CLASS_W-1:0]   nxt_best_class;
    logic [CLASS_W-1:0]   sample_class;
`ifdef LGN_SCHED_MARGIN_EN
    logic [SCORE_W-1:0]   second_score;
    logic [SCORE_W-1:0]   nxt_second;
`endif

    assign in_ready = (state == ST_LOAD);

    // phase k (1..CLASSES) carries the registered score of class k-1
    assign sample_class = CLASS_W'(phase - PH_W'(1));

    always_comb begin
        nxt_best_score = best_score;
        nxt_best_class = best_class;
        if (phase == PH_W'(1)) begin
            nxt_best_score = score;
            nxt_best_class = '0;
        end else if (score > best_score) begin
            nxt_best_score = score;
            nxt_best_class = sample_class;
        end
    end

`ifdef LGN_SCHED_MARGIN_EN
    always_comb begin
        nxt_second = second_score;
        if (phase == PH_W'(1))
            nxt_second = '0;
        else if (score > best_score)
            nxt_second = best_score;
        else if (score > second_score)
            nxt_second = score;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_LOAD;
            byte_cnt     <= '0;
            settle_cnt   <= '0;
            phase        <= '0;
            best_score   <= '0;
            best_class   <= '0;
            x_shift      <= 1'b0;
            x_byte       <= '0;
            class_sel    <= '0;
            result_valid <= 1'b0;
            result_class <= '0;
            result_score <= '0;
            busy         <= 1'b0;
`ifdef LGN_SCHED_MARGIN_EN
            second_score  <= '0;
            result_margin <= '0;
`endif
        end else begin
            x_shift <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (in_valid) begin
                        x_shift <= 1'b1;
                        x_byte  <= in_data;
                        if (byte_cnt == CNT_W'(INPUT_BYTES - 1)) begin
                            byte_cnt   <= '0;
                            settle_cnt <= SET_W'(SETTLE_CYCLES);
                            busy       <= 1'b1;
                            state      <= ST_SETTLE;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        class_sel <= '0;
                        phase     <= '0;
                        state     <= ST_SCORE;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                ST_SCORE: begin
                    if (class_sel != CLASS_W'(CLASSES - 1))
                        class_sel <= class_sel + CLASS_W'(1);
                    phase <= phase + PH_W'(1);
                    if (phase != '0) begin
                        best_score <= nxt_best_score;
                        best_class <= nxt_best_class;
`ifdef LGN_SCHED_MARGIN_EN
                        second_score <= nxt_second;
`endif
                    end
                    if (phase == PH_W'(CLASSES)) begin
                        result_class <= nxt_best_class;
                        result_score <= nxt_best_score;
`ifdef LGN_SCHED_MARGIN_EN
                        result_margin <= nxt_best_score - nxt_second;
`endif
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= ST_LOAD;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_lgn_class_scheduler.sv
// Scoreboard bench for lgn_class_scheduler: byte queue checked on x_shift, result queue
// checked on result_valid. Margin checks follow LGN_SCHED_MARGIN_EN.
module tb_lgn_class_scheduler;

    localparam int CLASSES = 10;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       x_shift;
    logic [7:0] x_byte;
    logic [3:0] class_sel;
    logic [8:0] score;
    logic       result_valid;
    logic       result_ready;
    logic [3:0] result_class;
    logic [8:0] result_score;
    logic       busy;
`ifdef LGN_SCHED_MARGIN_EN
    logic [8:0] result_margin;
`endif

    lgn_class_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .x_shift      (x_shift),
        .x_byte       (x_byte),
        .class_sel    (class_sel),
        .score        (score),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_class (result_class),
        .result_score (result_score),
`ifdef LGN_SCHED_MARGIN_EN
        .result_margin(result_margin),
`endif
        .busy         (busy)
    );

    typedef struct {
        int cls;
        int sc;
        int mg;
    } res_t;

    int         compared = 0;
    int         mismatched = 0;
    int         tbl [CLASSES];
    logic [7:0] xq [$];
    res_t       rq [$];
    logic [3:0] cs;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // external popcount register: score follows class_sel by one cycle
    initial begin
        score = '0;
        forever begin
            @(negedge clk);
            cs = class_sel;
            @(posedge clk);
            #1;
            score = (cs < CLASSES) ? 9'(tbl[cs]) : 9'd0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && x_shift) begin
            if (xq.size() == 0)
                chk_eq("x_shift_unexpected", 32'd1, 32'd0);
            else
                chk_eq("x_byte", x_byte, xq.pop_front());
        end
    end

    function automatic res_t model();
        res_t r;
        int bi = 0;
        int sec = 0;
        for (int i = 1; i < CLASSES; i++)
            if (tbl[i] > tbl[bi]) bi = i;
        for (int i = 0; i < CLASSES; i++)
            if (i != bi && tbl[i] > sec) sec = tbl[i];
        r.cls = bi;
        r.sc  = tbl[bi];
        r.mg  = tbl[bi] - sec;
        return r;
    endfunction

    task automatic load_image(input int base, input bit push_res);
        if (push_res) rq.push_back(model());
        for (int i = 0; i < 32; i++) begin
            chk_eq("in_ready_load", in_ready, 1'b1);
            in_valid = 1'b1;
            in_data  = 8'(base + i);
            xq.push_back(8'(base + i));
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk_eq("in_ready_after_last", in_ready, 1'b0);
    endtask

    task automatic wait_result(input bit ign);
        int n = 0;
        while (!result_valid && n < 100) begin
            if (n == 1) chk_eq("busy_settle", busy, 1'b1);
            in_valid = ign && n[0];
            in_data  = 8'hEE;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk_eq("latency", n, 16);
    endtask

    task automatic take_result(input int hold, input bit keep);
        res_t e;
        if (rq.size() == 0) begin
            chk_eq("rq_empty", 32'd1, 32'd0);
            e.cls = 0; e.sc = 0; e.mg = 0;
        end else begin
            e = rq.pop_front();
        end
        chk_eq("result_class", result_class, e.cls);
        chk_eq("result_score", result_score, e.sc);
`ifdef LGN_SCHED_MARGIN_EN
        chk_eq("result_margin", result_margin, e.mg);
`endif
        for (int i = 0; i < hold; i++) begin
            result_ready = 1'b0;
            in_valid     = keep;
            in_data      = 8'h40;
            @(negedge clk);
            chk_eq("hold_valid", result_valid, 1'b1);
            chk_eq("hold_class", result_class, e.cls);
            chk_eq("hold_score", result_score, e.sc);
            chk_eq("hold_ready", in_ready, 1'b0);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk_eq("hs_valid_drop", result_valid, 1'b0);
        chk_eq("hs_in_ready", in_ready, 1'b1);
        chk_eq("hs_no_shift", x_shift, 1'b0);
        chk_eq("hs_busy", busy, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk_eq({tag, "_x_shift"}, x_shift, 1'b0);
        chk_eq({tag, "_x_byte"}, x_byte, 8'h00);
        chk_eq({tag, "_class_sel"}, class_sel, 4'd0);
        chk_eq({tag, "_result_valid"}, result_valid, 1'b0);
        chk_eq({tag, "_result_class"}, result_class, 4'd0);
        chk_eq({tag, "_result_score"}, result_score, 9'd0);
        chk_eq({tag, "_busy"}, busy, 1'b0);
        chk_eq({tag, "_in_ready"}, in_ready, 1'b1);
`ifdef LGN_SCHED_MARGIN_EN
        chk_eq({tag, "_result_margin"}, result_margin, 9'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        result_ready = 1'b0;
        tbl = '{default: 0};
        @(negedge clk);
        @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;
        @(negedge clk);

        // arg-max with tie at the top: lowest index wins, margin 0; then backpressure
        tbl = '{12, 40, 7, 40, 3, 0, 39, 1, 2, 5};
        load_image(8'h00, 1'b1);
        wait_result(1'b1);
        take_result(20, 1'b1);

        tbl = '{5, 9, 300, 4, 0, 0, 0, 0, 0, 299};
        load_image(8'h40, 1'b1);
        wait_result(1'b0);
        take_result(0, 1'b0);

        // full-scale score on the last class
        tbl = '{510, 0, 0, 0, 0, 0, 0, 0, 0, 511};
        load_image(8'h60, 1'b1);
        wait_result(1'b1);
        take_result(0, 1'b0);

        for (int i = 0; i < CLASSES; i++) tbl[i] = int'($urandom_range(0, 511));
        tbl[7] = tbl[3];
        load_image(8'hA0, 1'b1);
        wait_result(1'b1);
        take_result(0, 1'b0);

        // reset in the middle of SCORE discards the image
        tbl = '{12, 40, 7, 40, 3, 0, 39, 1, 2, 5};
        load_image(8'h80, 1'b0);
        for (int i = 0; i < 9; i++) @(negedge clk);
        chk_eq("pre_reset_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_score");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tbl = '{5, 9, 300, 4, 0, 0, 0, 0, 0, 299};
        load_image(8'hC0, 1'b1);
        wait_result(1'b0);
        take_result(3, 1'b0);

        @(negedge clk);
        chk_eq("xq_drained", xq.size(), 0);
        chk_eq("rq_drained", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
